// File: rtl/matvec_result_packer.sv
`timescale 1ns/1ps
// Purpose: bias-add, round, saturate matvec row results and pack BANDWIDTH rows per output word.
// Latency: out_valid rises the cycle after the edge that accepts a word's final row.
// Backpressure: FIFO_DEPTH-word show-ahead FIFO; a push into a full FIFO drops the word and sets overflow.
module matvec_result_packer #(
    parameter int MAX_ROWS   = 64,
    parameter int BANDWIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [$clog2(MAX_ROWS):0]       num_rows,
    input  logic                            bias_write_enable,
    input  logic [$clog2(MAX_ROWS)-1:0]     bias_base_addr,
    input  logic [DATA_WIDTH*BANDWIDTH-1:0] bias_in,
    input  logic [2*DATA_WIDTH-1:0]         result_in,
    input  logic                            result_valid_in,
    output logic [DATA_WIDTH*BANDWIDTH-1:0] out_data,
    output logic [$clog2(MAX_ROWS)-1:0]     out_base_addr,
    output logic                            out_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow
);
    localparam int AW = $clog2(MAX_ROWS);
    localparam int NW = AW + 1;
    localparam int LW = $clog2(BANDWIDTH);
    localparam int WW = DATA_WIDTH * BANDWIDTH;
    localparam int SW = 2 * DATA_WIDTH + 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic signed [SW-1:0] MAXV = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = ~MAXV;
    localparam logic signed [SW-1:0] RND  = {{(SW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    typedef struct packed {
        logic          last;
        logic [AW-1:0] base;
        logic [WW-1:0] dat;
    } word_t;

    state_t          state;
    logic [NW-1:0]   row_cnt;
    logic [NW-1:0]   num_rows_q;
    logic [WW-1:0]   pack_q;
    logic [DATA_WIDTH-1:0] bias_mem [MAX_ROWS];

    word_t           fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_cnt;

    logic                  accept;
    logic                  last_row;
    logic [LW-1:0]         lane;
    logic [DATA_WIDTH-1:0] bias_rd;
    logic signed [SW-1:0]  res_ext;
    logic signed [SW-1:0]  bias_ext;
    logic signed [SW-1:0]  sum;
    logic signed [SW-1:0]  y;
    logic [DATA_WIDTH-1:0] elem;
    logic [WW-1:0]         word_nxt;
    word_t                 push_word;
    word_t                 head;
    logic                  push_vld;
    logic                  push_rdy;
    logic                  fifo_push;
    logic                  fifo_pop;

    assign busy     = (state != IDLE);
    assign lane     = row_cnt[LW-1:0];
    assign accept   = (state == COLLECT) && result_valid_in && (row_cnt < num_rows_q);
    assign last_row = (row_cnt == num_rows_q - NW'(1));
    // Read happens before this edge's bias write lands, so a same-cycle write sees the old bias.
    assign bias_rd  = bias_mem[row_cnt[AW-1:0]];

    always_comb begin
        res_ext  = {{2{result_in[2*DATA_WIDTH-1]}}, result_in};
        bias_ext = {{(SW-DATA_WIDTH){bias_rd[DATA_WIDTH-1]}}, bias_rd};
        sum      = res_ext + (bias_ext <<< FRAC_BITS) + RND;
        y        = sum >>> FRAC_BITS;
        if (y > MAXV)
            elem = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (y < MINV)
            elem = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            elem = y[DATA_WIDTH-1:0];
        word_nxt = pack_q;
        word_nxt[lane*DATA_WIDTH +: DATA_WIDTH] = elem;
    end

    always_comb begin
        push_vld       = accept && ((lane == LW'(BANDWIDTH-1)) || last_row);
        push_word.last = last_row;
        push_word.base = {row_cnt[AW-1:LW], {LW{1'b0}}};
        push_word.dat  = word_nxt;
    end

    assign fifo_pop  = out_valid && out_ready;
    assign push_rdy  = (fifo_cnt < CW'(FIFO_DEPTH)) || fifo_pop;
    assign fifo_push = push_vld && push_rdy;
    assign out_valid = (fifo_cnt != '0);
    assign head      = fifo_mem[rd_ptr];

    assign out_data      = head.dat;
    assign out_base_addr = head.base;
    assign out_last      = head.last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_ROWS; i++)
                bias_mem[i] <= '0;
        end else if (bias_write_enable) begin
            for (int i = 0; i < BANDWIDTH; i++)
                bias_mem[bias_base_addr + AW'(i)] <= bias_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                fifo_mem[wr_ptr] <= push_word;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (fifo_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row_cnt    <= '0;
            num_rows_q <= '0;
            pack_q     <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_rows_q <= num_rows;
                        row_cnt    <= '0;
                        pack_q     <= '0;
                        overflow   <= 1'b0;
                        state      <= (num_rows == '0) ? DRAIN : COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        row_cnt <= row_cnt + NW'(1);
                        if (push_vld) begin
                            pack_q <= '0;
                            if (!push_rdy)
                                overflow <= 1'b1;
                            if (last_row)
                                state <= DRAIN;
                        end else begin
                            pack_q <= word_nxt;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matvec_result_packer.sv
`timescale 1ns/1ps
// Directed bench for matvec_result_packer: a FIFO_DEPTH=4 instance for most passes and a
// FIFO_DEPTH=2 instance for the overflow pass; inputs driven 1ns after posedge, outputs sampled there too.
module tb_matvec_result_packer;
    localparam int DW = 16;
    localparam int BW = 16;
    localparam int AW = 6;
    localparam int NW = 7;
    localparam int WW = DW * BW;

    typedef struct {
        logic [31:0] res;
        logic [15:0] bias;
        logic [15:0] expv;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_0, start_1;
    logic [NW-1:0] num_rows;
    logic          bias_write_enable;
    logic [AW-1:0] bias_base_addr;
    logic [WW-1:0] bias_in;
    logic [31:0]   result_in;
    logic          result_valid_in;
    logic          out_ready;

    logic [WW-1:0] out_data_0, out_data_1;
    logic [AW-1:0] out_base_addr_0, out_base_addr_1;
    logic          out_last_0, out_last_1, out_valid_0, out_valid_1;
    logic          busy_0, busy_1, done_0, done_1, overflow_0, overflow_1;

    int checks = 0;
    int errors = 0;

    matvec_result_packer #(.FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_0), .num_rows(num_rows),
        .bias_write_enable(bias_write_enable), .bias_base_addr(bias_base_addr), .bias_in(bias_in),
        .result_in(result_in), .result_valid_in(result_valid_in),
        .out_data(out_data_0), .out_base_addr(out_base_addr_0), .out_last(out_last_0),
        .out_valid(out_valid_0), .out_ready(out_ready),
        .busy(busy_0), .done(done_0), .overflow(overflow_0)
    );

    matvec_result_packer #(.FIFO_DEPTH(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_1), .num_rows(num_rows),
        .bias_write_enable(bias_write_enable), .bias_base_addr(bias_base_addr), .bias_in(bias_in),
        .result_in(result_in), .result_valid_in(result_valid_in),
        .out_data(out_data_1), .out_base_addr(out_base_addr_1), .out_last(out_last_1),
        .out_valid(out_valid_1), .out_ready(out_ready),
        .busy(busy_1), .done(done_1), .overflow(overflow_1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference element: Q8.24 result + Q4.12 bias, round half up, saturate to Q4.12.
    function automatic logic [15:0] model(input logic [31:0] res, input logic [15:0] b);
        longint s;
        longint y;
        logic [63:0] yv;
        s = longint'($signed(res)) + longint'($signed(b)) * 4096 + 2048;
        y = s >>> 12;
        if (y > 32767) return 16'h7FFF;
        if (y < -32768) return 16'h8000;
        yv = 64'(y);
        return yv[15:0];
    endfunction

    // Expected word for rows base..base+15 of a pass of n rows where row r carries r<<24 and zero bias.
    function automatic logic [WW-1:0] exp_word(input int base, input int n);
        logic [WW-1:0] w;
        w = '0;
        for (int l = 0; l < BW; l++)
            if (base + l < n)
                w[l*DW +: DW] = model(32'(base + l) << 24, 16'h0000);
        return w;
    endfunction

    task automatic write_bias(input logic [AW-1:0] base, input logic [WW-1:0] val);
        bias_write_enable = 1'b1;
        bias_base_addr    = base;
        bias_in           = val;
        tick();
        bias_write_enable = 1'b0;
    endtask

    // One-row pass on dut0 with whatever bias[0] currently holds.
    task automatic pass1(input string name, input logic [31:0] res, input logic [15:0] expv);
        start_0 = 1'b1; num_rows = NW'(1);
        tick();
        start_0 = 1'b0;
        chk({name, " busy"}, WW'(busy_0), WW'(1));
        result_in = res; result_valid_in = 1'b1;
        tick();
        result_valid_in = 1'b0;
        chk({name, " valid"}, WW'(out_valid_0), WW'(1));
        chk({name, " data"}, out_data_0, WW'(expv));
        chk({name, " last"}, WW'(out_last_0), WW'(1));
        chk({name, " base"}, WW'(out_base_addr_0), WW'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, " drained"}, WW'({out_valid_0, done_0}), WW'(0));
        tick();
        chk({name, " done"}, WW'({done_0, busy_0}), WW'(2'b10));
    endtask

    task automatic run20(input string name);
        start_0 = 1'b1; num_rows = NW'(20);
        tick();
        start_0 = 1'b0;
        for (int r = 0; r < 20; r++) begin
            result_in = 32'(r) << 24; result_valid_in = 1'b1;
            tick();
            if (r == 15) begin
                chk({name, " w0 valid"}, WW'(out_valid_0), WW'(1));
                chk({name, " w0 data"}, out_data_0, exp_word(0, 20));
                chk({name, " w0 base"}, WW'(out_base_addr_0), WW'(0));
                chk({name, " w0 last"}, WW'(out_last_0), WW'(0));
            end
        end
        // A result beyond num_rows must not disturb the packed words.
        result_in = 32'h7FFF_FFFF;
        tick();
        result_valid_in = 1'b0;
        chk({name, " held"}, WW'({busy_0, out_valid_0, out_base_addr_0}), WW'({2'b11, 6'd0}));
        out_ready = 1'b1;
        tick();
        chk({name, " w1 data"}, out_data_0, exp_word(16, 20));
        chk({name, " w1 base"}, WW'(out_base_addr_0), WW'(16));
        chk({name, " w1 last"}, WW'({out_valid_0, out_last_0}), WW'(2'b11));
        tick();
        out_ready = 1'b0;
        chk({name, " empty"}, WW'({out_valid_0, done_0}), WW'(0));
        tick();
        chk({name, " done"}, WW'({done_0, busy_0}), WW'(2'b10));
        tick();
        chk({name, " done pulse"}, WW'(done_0), WW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[9];
        logic [WW-1:0] w;

        vecs[0] = '{32'h0300_0000, 16'h0800, 16'h3800};
        vecs[1] = '{32'h7FFF_FFFF, 16'h0000, 16'h7FFF};
        vecs[2] = '{32'h8000_0000, 16'h0000, 16'h8000};
        vecs[3] = '{32'h0000_0800, 16'h0000, 16'h0001};
        vecs[4] = '{32'hFFFF_F800, 16'h0000, 16'h0000};
        vecs[5] = '{32'h0000_07FF, 16'h0000, 16'h0000};
        vecs[6] = '{32'hFFFF_F7FF, 16'h0000, 16'hFFFF};
        vecs[7] = '{32'h0100_0000, 16'hF000, 16'h0000};
        vecs[8] = '{32'h7F00_0000, 16'h7FFF, 16'h7FFF};

        rst = 1'b1; start_0 = 1'b0; start_1 = 1'b0; num_rows = '0;
        bias_write_enable = 1'b0; bias_base_addr = '0; bias_in = '0;
        result_in = '0; result_valid_in = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset flags", WW'({out_valid_0, busy_0, done_0, overflow_0, out_last_0}), WW'(0));
        chk("reset data", out_data_0, '0);
        chk("reset base", WW'(out_base_addr_0), WW'(0));

        // Single-row arithmetic vectors.
        for (int i = 0; i < 9; i++) begin
            write_bias(6'd0, WW'(vecs[i].bias));
            pass1($sformatf("vec%0d", i), vecs[i].res, vecs[i].expv);
        end

        // Same-cycle bias write and result: the old bias applies, the new one on the next pass.
        write_bias(6'd0, WW'(16'h1000));
        start_0 = 1'b1; num_rows = NW'(1);
        tick();
        start_0 = 1'b0;
        result_in = 32'h0; result_valid_in = 1'b1;
        bias_write_enable = 1'b1; bias_base_addr = 6'd0; bias_in = WW'(16'h2000);
        tick();
        result_valid_in = 1'b0; bias_write_enable = 1'b0;
        chk("old bias data", out_data_0, WW'(16'h1000));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("old bias done", WW'(done_0), WW'(1));
        pass1("new bias", 32'h0, 16'h2000);
        write_bias(6'd0, '0);

        // Four rows packed into lanes 0..3 of one word.
        start_0 = 1'b1; num_rows = NW'(4);
        tick();
        start_0 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            result_in = vecs[i].res; result_valid_in = 1'b1;
            tick();
        end
        result_valid_in = 1'b0;
        w = '0;
        w[15:0] = 16'h7FFF; w[31:16] = 16'h8000; w[47:32] = 16'h0001; w[63:48] = 16'h0000;
        chk("pack4 data", out_data_0, w);
        chk("pack4 last", WW'({out_valid_0, out_last_0}), WW'(2'b11));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("pack4 done", WW'(done_0), WW'(1));

        run20("rows20");

        // Zero-row pass goes straight to drain and completes.
        start_0 = 1'b1; num_rows = '0;
        tick();
        start_0 = 1'b0;
        chk("zero rows busy", WW'({busy_0, done_0, out_valid_0}), WW'(3'b100));
        tick();
        chk("zero rows done", WW'({busy_0, done_0}), WW'(2'b01));

        // 64 rows with the consumer stalled fill the 4-deep FIFO exactly.
        start_0 = 1'b1; num_rows = NW'(64);
        tick();
        start_0 = 1'b0;
        for (int r = 0; r < 64; r++) begin
            result_in = 32'(r) << 24; result_valid_in = 1'b1;
            start_0 = (r == 10);
            if (r == 10) num_rows = NW'(2);
            tick();
            start_0 = 1'b0;
        end
        result_valid_in = 1'b0;
        tick(); tick(); tick();
        chk("full hold", WW'({out_valid_0, overflow_0, busy_0, done_0}), WW'(4'b1010));
        chk("full head data", out_data_0, exp_word(0, 64));
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("beat%0d base", k), WW'({out_valid_0, out_base_addr_0}), WW'({1'b1, 6'(k * 16)}));
            chk($sformatf("beat%0d last", k), WW'(out_last_0), WW'(k == 3));
            tick();
        end
        out_ready = 1'b0;
        chk("beats drained", WW'({out_valid_0, done_0}), WW'(0));
        tick();
        chk("beats done", WW'({done_0, busy_0}), WW'(2'b10));

        // 2-deep instance: third word (rows 32..47) is dropped.
        start_1 = 1'b1; num_rows = NW'(64);
        tick();
        start_1 = 1'b0;
        for (int r = 0; r < 64; r++) begin
            result_in = 32'(r) << 24; result_valid_in = 1'b1;
            tick();
            if (r == 46) chk("ovf before row47", WW'(overflow_1), WW'(0));
            if (r == 47) chk("ovf at row47", WW'(overflow_1), WW'(1));
        end
        result_valid_in = 1'b0;
        chk("ovf hold", WW'({busy_1, out_valid_1, overflow_1}), WW'(3'b111));
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ovf beat%0d", k), WW'({out_valid_1, out_last_1, out_base_addr_1}), WW'({2'b10, 6'(k * 16)}));
            tick();
        end
        out_ready = 1'b0;
        chk("ovf drained", WW'({out_valid_1, done_1}), WW'(0));
        tick();
        chk("ovf done", WW'({done_1, busy_1, overflow_1}), WW'(3'b101));
        start_1 = 1'b1; num_rows = '0;
        tick();
        start_1 = 1'b0;
        chk("ovf cleared by start", WW'(overflow_1), WW'(0));
        tick();

        // Reset in the middle of collecting, then a normal pass.
        start_0 = 1'b1; num_rows = NW'(20);
        tick();
        start_0 = 1'b0;
        for (int r = 0; r < 5; r++) begin
            result_in = 32'(r) << 24; result_valid_in = 1'b1;
            tick();
        end
        rst = 1'b1;
        #2;
        chk("midrst flags", WW'({out_valid_0, busy_0, done_0, overflow_0}), WW'(0));
        tick();
        rst = 1'b0; result_valid_in = 1'b0;
        tick();
        chk("midrst no done", WW'({done_0, busy_0}), WW'(0));
        run20("after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
